// File: rtl/rdy_set_go_seq.sv
// Start sequencer for the Simon Says game: timed "rdy"/"SEt"/"GO" countdown,
// score keeping during play, and win/lose display on a scanned active-low 7-seg.
module rdy_set_go_seq #(
  parameter int DIGITS      = 4,
  parameter int STAGE_TICKS = 100000000,
  parameter int SCAN_TICKS  = 100000,
  parameter int WIN_SCORE   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [1:0]        correct,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,      // seg[6] = segment a ... seg[0] = g; literals read abcdefg
  output logic              play_en,
  output logic              win,
  output logic              lose,
  output logic [6:0]        score
);

  localparam int SW  = (STAGE_TICKS > 1) ? $clog2(STAGE_TICKS) : 1;
  localparam int SCW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int IW  = $clog2(DIGITS);

  localparam logic [SW-1:0]  STAGE_LAST = SW'(STAGE_TICKS - 1);
  localparam logic [SCW-1:0] SCAN_LAST  = SCW'(SCAN_TICKS - 1);
  localparam logic [IW-1:0]  IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [6:0]     SCORE_MAX  = 7'd99;
  localparam logic [6:0]     SCORE_WIN  = 7'(WIN_SCORE);

  localparam logic [6:0] G_BLANK = 7'b1111111;
  localparam logic [6:0] G_DASH  = 7'b1111110;
  localparam logic [6:0] G_R     = 7'b1111010;
  localparam logic [6:0] G_D     = 7'b1000010;
  localparam logic [6:0] G_Y     = 7'b1000100;
  localparam logic [6:0] G_S     = 7'b0100100;
  localparam logic [6:0] G_E     = 7'b0110000;
  localparam logic [6:0] G_T     = 7'b1110000;
  localparam logic [6:0] G_G     = 7'b0100001;
  localparam logic [6:0] G_O     = 7'b0000001;
  localparam logic [6:0] G_L     = 7'b1110001;

  typedef enum logic [2:0] {
    S_IDLE, S_READY, S_SET, S_GO, S_PLAY, S_WIN, S_LOSE
  } state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   stage_cnt, stage_nxt;
  logic [SCW-1:0]  scan_cnt;
  logic [IW-1:0]   scan_idx;
  logic [6:0]      score_nxt;
  logic            go_q;
  logic [1:0]      correct_q;
  logic            go_edge;
  logic            cor_evt;

  assign go_edge = go && !go_q;
  assign cor_evt = (correct != 2'b00) && (correct_q == 2'b00);

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return G_BLANK;
    endcase
  endfunction

  // Glyph for digit position pos (0 = rightmost) of the text shown in state st.
  function automatic logic [6:0] text_glyph(input state_t st, input int unsigned pos,
                                            input logic [6:0] sc);
    logic [6:0] g;
    logic [3:0] tens;
    logic [3:0] ones;
    g    = G_BLANK;
    tens = 4'(sc / 7'd10);
    ones = 4'(sc % 7'd10);
    case (st)
      S_IDLE:  g = G_DASH;
      S_READY: case (pos) 2: g = G_R; 1: g = G_D; 0: g = G_Y; default: g = G_BLANK; endcase
      S_SET:   case (pos) 2: g = G_S; 1: g = G_E; 0: g = G_T; default: g = G_BLANK; endcase
      S_GO:    case (pos) 1: g = G_G; 0: g = G_O; default: g = G_BLANK; endcase
      S_PLAY: begin
        if (pos == 0)                   g = digit_glyph(ones);
        else if (pos == 1 && tens != 0) g = digit_glyph(tens);
      end
      S_WIN:   case (pos) 3: g = G_G; 2: g = G_O; 1: g = G_O; 0: g = G_D; default: g = G_BLANK; endcase
      S_LOSE:  case (pos) 3: g = G_L; 2: g = G_O; 1: g = G_S; 0: g = G_E; default: g = G_BLANK; endcase
      default: g = G_BLANK;
    endcase
    return g;
  endfunction

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt = state;
    stage_nxt = '0;
    score_nxt = score;
    case (state)
      S_IDLE: if (go_edge) state_nxt = S_READY;
      S_READY: begin
        if (stage_cnt == STAGE_LAST) state_nxt = S_SET;
        else                         stage_nxt = stage_cnt + SW'(1);
      end
      S_SET: begin
        if (stage_cnt == STAGE_LAST) state_nxt = S_GO;
        else                         stage_nxt = stage_cnt + SW'(1);
      end
      S_GO: begin
        if (stage_cnt == STAGE_LAST) begin
          state_nxt = S_PLAY;
          score_nxt = '0;
        end else begin
          stage_nxt = stage_cnt + SW'(1);
        end
      end
      S_PLAY: begin
        if (cor_evt) begin
          if (correct == 2'b01) begin
            score_nxt = (score == SCORE_MAX) ? SCORE_MAX : score + 7'd1;
            if (score_nxt == SCORE_WIN) state_nxt = S_WIN;
          end else begin
            state_nxt = S_LOSE;
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (go_edge) begin
          state_nxt = S_READY;
          score_nxt = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      stage_cnt <= '0;
      scan_cnt  <= '0;
      scan_idx  <= '0;
      go_q      <= 1'b0;
      correct_q <= 2'b00;
      score     <= '0;
      an        <= '1;
      seg       <= G_BLANK;
      play_en   <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;
    end else begin
      state     <= state_nxt;
      stage_cnt <= stage_nxt;
      score     <= score_nxt;
      go_q      <= go;
      correct_q <= correct;
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
      end else begin
        scan_cnt <= scan_cnt + SCW'(1);
      end
      // an and seg both come from the same digit index, so they always switch together.
      an      <= ~(DIGITS'(1) << scan_idx);
      seg     <= text_glyph(state_nxt, 32'(scan_idx), score_nxt);
      play_en <= (state_nxt == S_PLAY);
      win     <= (state_nxt == S_WIN);
      lose    <= (state_nxt == S_LOSE);
    end
  end

endmodule
